// File: rtl/stack_port_ctrl.sv
// rtl/stack_port_ctrl.sv - upstream push / read-request front end for an external LIFO stack
// Words are pushed from a valid/ready stream; a read pops one word and holds it until taken.
module stack_port_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   output logic              stk_push,
   output logic              stk_pop,
   output logic [DATA_W-1:0] stk_din,
   input  logic [DATA_W-1:0] stk_dout,
   input  logic              stk_empty,
   input  logic              stk_full,
   output logic [OCC_W-1:0]  occ,
   output logic              udf_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      CAPT = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

   state_t              state_q, state_d;
   logic                rd_pend_q, rd_pend_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [OCC_W-1:0]    occ_q, occ_d;
   logic                udf_err_q, udf_err_d;
   logic                push_w;
   logic                pop_w;

   // A pending pop on a non-empty stack closes the write side so push and pop never overlap.
   assign in_ready = (state_q == IDLE) & ~stk_full & ~(rd_pend_q & ~stk_empty);
   assign push_w   = in_valid & in_ready;
   assign pop_w    = (state_q == POP);

   assign stk_push = push_w;
   assign stk_din  = in_data;
   assign stk_pop  = pop_w;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign occ      = occ_q;
   assign udf_err  = udf_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         occ_q      <= '0;
         udf_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_pend_q  <= rd_pend_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         occ_q      <= occ_d;
         udf_err_q  <= udf_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_pend_d  = rd_pend_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      udf_err_d  = udf_err_q;
      unique case (state_q)
         IDLE: begin
            if (rd_pend_q && !stk_empty) begin
               state_d   = POP;
               rd_pend_d = 1'b0;
            end else if (rd_req && !rd_pend_q) begin
               // A same-cycle push makes the stack non-empty in time for the pop.
               if (!stk_empty || push_w) begin
                  rd_pend_d = 1'b1;
               end else begin
                  udf_err_d = 1'b1;
               end
            end
         end
         POP: begin
            state_d = CAPT;
         end
         CAPT: begin
            rd_data_d  = stk_dout;
            rd_valid_d = 1'b1;
            state_d    = HOLD;
         end
         HOLD: begin
            if (rd_valid_q && rd_ready) begin
               rd_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      if (push_w && (occ_q != OCC_MAX)) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (pop_w && (occ_q != '0)) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   a_no_push_pop: assert property (@(posedge clk) disable iff (!rstn) !(stk_push && stk_pop));
   a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
                                   (rd_valid && !rd_ready) |=> (rd_valid && $stable(rd_data)));

endmodule

// File: tb/tb_stack_port_ctrl.sv
// tb/tb_stack_port_ctrl.sv - scoreboard bench for stack_port_ctrl with a behavioural stack
// Expected popped words are queued at rd_req; a negedge monitor compares on each rd handshake.
module tb_stack_port_ctrl;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int OCC_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rstn;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              rd_req;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ready;
   logic              stk_push;
   logic              stk_pop;
   logic [DATA_W-1:0] stk_din;
   logic [DATA_W-1:0] stk_dout;
   logic              stk_empty;
   logic              stk_full;
   logic [OCC_W-1:0]  occ;
   logic              udf_err;

   int total = 0;
   int bad   = 0;
   int push_cnt = 0;
   int pop_cnt  = 0;
   logic [DATA_W-1:0] exp_q[$];

   logic [DATA_W-1:0] mem [DEPTH];
   int sp;

   always #5 clk = ~clk;

   stack_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rd_req    (rd_req),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .stk_empty (stk_empty),
      .stk_full  (stk_full),
      .occ       (occ),
      .udf_err   (udf_err)
   );

   // Stack model: dout is valid the cycle after the pop edge, reset along with the DUT.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_push && sp < DEPTH) begin
         mem[sp] <= stk_din;
         sp      <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_dout <= mem[sp-1];
         sp       <= sp - 1;
      end
   end
   assign stk_empty = (sp == 0);
   assign stk_full  = (sp == DEPTH);

   always @(negedge clk) begin
      if (rstn) begin
         if (stk_push) push_cnt++;
         if (stk_pop)  pop_cnt++;
         if (rd_valid && rd_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got=%0h want=none", rd_data);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  bad++;
                  $display("FAIL sb_data: got=%0h want=%0h", rd_data, e);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic psh(input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      chk("push_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Issue rd_req (optionally with a same-cycle push) and measure latency to rd_valid.
   task automatic rd(input logic [DATA_W-1:0] exp, input bit ready, input bit with_push);
      int lat;
      rd_ready = ready;
      rd_req   = 1'b1;
      if (with_push) begin
         in_valid = 1'b1;
         in_data  = exp;
      end
      exp_q.push_back(exp);
      tick();
      rd_req   = 1'b0;
      in_valid = 1'b0;
      lat = 0;
      while (!rd_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk("rd_latency", 32'(lat), 32'd3);
      if (ready) begin
         tick();
         chk("rd_released", 32'(rd_valid), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pc;
      logic [DATA_W-1:0] v;
      rstn = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_ready = 1'b0;
      #2;
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_occ",      32'(occ),      32'd0);
      chk("rst_udf",      32'(udf_err),  32'd0);
      chk("rst_push",     32'(stk_push), 32'd0);
      chk("rst_pop",      32'(stk_pop),  32'd0);
      chk("rst_rd_data",  32'(rd_data),  32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // Four pushes then a read that stalls in HOLD.
      psh(8'h11); psh(8'h22); psh(8'h33); psh(8'h44);
      chk("occ_after4",  32'(occ),     32'd4);
      chk("push_cnt4",   32'(push_cnt), 32'd4);
      rd(8'h44, 1'b0, 1'b0);
      chk("occ_after_rd", 32'(occ), 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk("hold_data",  32'(rd_data),  32'h44);
         chk("hold_ready", 32'(in_ready), 32'd0);
         tick();
      end
      chk("hold_pops", 32'(pop_cnt), 32'd1);
      rd_ready = 1'b1;
      tick();
      chk("hold_release", 32'(rd_valid), 32'd0);
      chk("idle_ready",   32'(in_ready), 32'd1);

      // Fill to capacity and hold in_valid against a full stack.
      for (int i = 0; i < 5; i++) psh(8'h50 + 8'(i));
      in_valid = 1'b1;
      in_data  = 8'h99;
      for (int i = 0; i < 3; i++) begin
         chk("full_ready", 32'(in_ready), 32'd0);
         chk("full_flag",  32'(stk_full), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      chk("full_push_cnt", 32'(push_cnt), 32'd9);
      chk("full_occ",      32'(occ),      32'd8);
      chk("full_udf",      32'(udf_err),  32'd0);

      // Drain in LIFO order.
      for (int i = 4; i >= 0; i--) begin
         v = 8'h50 + 8'(i);
         rd(v, 1'b1, 1'b0);
      end
      rd(8'h33, 1'b1, 1'b0); rd(8'h22, 1'b1, 1'b0); rd(8'h11, 1'b1, 1'b0);
      chk("drain_occ", 32'(occ), 32'd0);

      // Read on empty stack raises sticky underflow.
      pc = pop_cnt;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("udf_no_valid", 32'(rd_valid), 32'd0);
         tick();
      end
      chk("udf_set",     32'(udf_err), 32'd1);
      chk("udf_no_pop",  32'(pop_cnt), 32'(pc));
      psh(8'hAA);
      chk("udf_sticky",  32'(udf_err), 32'd1);
      chk("udf_occ",     32'(occ),     32'd1);
      rd(8'hAA, 1'b1, 1'b0);

      // Clear the flag, then push and read together on an empty stack.
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      chk("rst2_udf", 32'(udf_err), 32'd0);
      rd(8'hBB, 1'b1, 1'b1);
      chk("same_cyc_udf", 32'(udf_err), 32'd0);
      chk("same_cyc_occ", 32'(occ),     32'd0);

      // Asynchronous reset while the pop is being captured.
      psh(8'h5A); psh(8'h6B);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      tick();
      rstn = 1'b0;
      #1;
      chk("arst_rd_valid", 32'(rd_valid), 32'd0);
      chk("arst_occ",      32'(occ),      32'd0);
      chk("arst_idle",     32'(in_ready), 32'd1);
      chk("arst_pop",      32'(stk_pop),  32'd0);
      tick();
      chk("arst_still", 32'(rd_valid), 32'd0);
      rstn = 1'b1;
      tick();
      psh(8'h77);
      chk("resync_occ", 32'(occ), 32'd1);
      rd(8'h77, 1'b1, 1'b0);

      tick();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_port_ctrl.md
STACK_PORT_CTRL -- requirements
Module: stack_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of the data path to and from the stack.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the stack capacity in entries; OCC_W = clog2(DEPTH+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream write word is valid.
REQ-006 SHALL have port in_data, input, DATA_W bits: the upstream write word.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 SHALL have port rd_req, input, 1 bit: single-cycle read request pulse.
REQ-009 SHALL have port rd_valid, output, 1 bit: rd_data holds a popped word.
REQ-010 SHALL have port rd_data, output, DATA_W bits: the popped word.
REQ-011 SHALL have port rd_ready, input, 1 bit: downstream takes rd_data.
REQ-012 SHALL have ports stk_push, stk_pop and stk_din[DATA_W], outputs: drive the stack's push, pop and din.
REQ-013 SHALL have ports stk_dout[DATA_W], stk_empty and stk_full, inputs: from the stack's dout, empty and full.
REQ-014 SHALL have port occ, output, OCC_W bits: tracked stack occupancy.
REQ-015 SHALL have port udf_err, output, 1 bit: sticky read-while-empty flag.

Function
REQ-016 SHALL use a stack contract where push/pop are sampled on the rising edge and stk_dout is valid in the cycle after the pop edge.
REQ-017 SHALL implement an FSM with states IDLE, POP, CAPT and HOLD.
REQ-018 SHALL drive in_ready = state==IDLE & !stk_full & !(rd_pend & !stk_empty).
REQ-019 SHALL drive stk_push = in_valid & in_ready and stk_din = in_data, combinationally.
REQ-020 SHALL, on an edge where rd_req=1 in IDLE with rd_pend=0 and stk_empty=0 (or stk_push=1 in the same cycle), set rd_pend.
REQ-021 SHALL, on rd_req=1 while stk_empty=1 and stk_push=0, set udf_err and leave rd_pend clear.
REQ-022 SHALL ignore rd_req while rd_pend=1 or the state is not IDLE: no queueing and no error.
REQ-023 SHALL transition IDLE->POP when rd_pend=1 & stk_empty=0, clearing rd_pend.
REQ-024 SHALL transition POP->CAPT unconditionally, with stk_pop=1 only in POP.
REQ-025 SHALL, in CAPT, register rd_data<=stk_dout and rd_valid<=1, then transition ->HOLD.
REQ-026 SHALL, in HOLD, keep rd_data stable while rd_valid=1; rd_valid&rd_ready clears rd_valid with ->IDLE on the same edge.
REQ-027 SHALL give a latency from the rd_req edge N to rd_valid=1 of 3 cycles (visible after edge N+3) when HOLD is not stalled.
REQ-028 SHALL never assert stk_push and stk_pop in the same cycle; a pending pop blocks pushes via in_ready.
REQ-029 SHALL increment occ by 1 on each stk_push edge and decrement it by 1 on each POP edge, saturating at DEPTH and 0.
REQ-030 SHALL exert full-stack backpressure by in_ready=0 only, never by raising an error.
REQ-031 SHALL keep udf_err sticky until reset.

Reset
REQ-032 SHALL, with rstn=0, asynchronously force state=IDLE, rd_pend=0, rd_valid=0, rd_data=0, occ=0 and udf_err=0; stk_push and stk_pop are then 0.
REQ-033 SHALL, on reset mid-operation (POP/CAPT/HOLD), discard the in-flight word and re-sync occ from 0 together with the stack's own reset.

Verification
REQ-034 SHALL cover: push 0x11,0x22,0x33,0x44 -> occ=4 and 4 stk_push pulses; rd_req -> rd_valid 3 cycles later with rd_data=0x44 and occ=3.
REQ-035 SHALL cover: hold rd_ready=0 for 5 cycles in HOLD -> rd_data stays 0x44, in_ready=0 and no stk_pop; then rd_ready=1 -> rd_valid=0 and state IDLE.
REQ-036 SHALL cover: fill to DEPTH=8 with stk_full=1 and in_valid held -> in_ready=0, no stk_push, occ=8 and udf_err=0.
REQ-037 SHALL cover: rd_req on an empty stack -> udf_err=1, no stk_pop and rd_valid stays 0; udf_err persists after a later push of 0xAA.
REQ-038 SHALL cover: in_valid with 0xBB and rd_req in the same cycle on an empty stack -> push accepted, no udf_err, pop returns 0xBB.
REQ-039 SHALL cover: rstn=0 asserted while in CAPT -> rd_valid=0, occ=0, state IDLE immediately, without waiting for a clock edge.
